// File: rtl/spi_master.sv
// spi_master: framed SPI master sending {cmd,wr_data} MSB first, with a delayed
// 8-bit readback for read-data frames and an enforced idle gap between frames.
module spi_master #(
    parameter int MISO_DLY = 4,
    parameter int IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    output logic       ready,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] SHIFT   = 3'd2;
    localparam logic [2:0] TAIL    = 3'd3;
    localparam logic [2:0] WAIT_RD = 3'd4;
    localparam logic [2:0] RECV    = 3'd5;
    localparam logic [2:0] GAP     = 3'd6;

    logic [2:0] state, nxt;
    logic [3:0] cnt, lim;
    logic [9:0] word;
    logic [7:0] sh;
    logic       rd, last;

    // lim is the number of cycles spent in the current state
    always_comb begin
        lim  = state == CMD     ? 4'd2 :
               state == SHIFT   ? 4'd10 :
               state == WAIT_RD ? 4'(MISO_DLY) :
               state == RECV    ? 4'd8 :
               state == GAP     ? 4'(IDLE_GAP) : 4'd1;
        last = cnt == lim - 4'd1;
        nxt  = state == IDLE    ? (start ? CMD : IDLE) :
               !last            ? state :
               state == CMD     ? SHIFT :
               state == SHIFT   ? (rd ? WAIT_RD : TAIL) :
               state == WAIT_RD ? RECV :
               state == GAP     ? IDLE : GAP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            word    <= 10'd0;
            rd      <= 1'b0;
            sh      <= 8'd0;
            rd_data <= 8'd0;
        end else begin
            state <= nxt;
            cnt   <= last ? 4'd0 : cnt + 4'd1;
            if (state == IDLE && start) begin
                word <= {cmd, wr_data};
                rd   <= &cmd;
            end
            if (state == SHIFT) word <= {word[8:0], 1'b0};
            if (state == RECV) sh <= {sh[6:0], MISO};
            if (state == RECV && last) rd_data <= {sh[6:0], MISO};
        end
    end

    assign ready    = state == IDLE;
    assign SS_n     = state == IDLE || state == GAP;
    assign MOSI     = (state == CMD || state == SHIFT) && word[9];
    assign done     = state == GAP && cnt == 4'd0;
    assign rd_valid = done && rd;
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter MISO_DLY, default 4: SS_n-low cycles between the last MOSI bit of a read-data frame and the first MISO sample (range 1..15).
REQ-002 Parameter IDLE_GAP, default 1: minimum SS_n-high cycles after every frame before the next frame may start (range 1..15).
REQ-003 clk  input  1  single clock; SS_n, MOSI and all other outputs change only on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  frame request, sampled on the rising edge of clk.
REQ-006 cmd  input  2  frame type: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-007 wr_data  input  8  payload (address or data byte).
REQ-008 ready  output  1  high when a start is accepted.
REQ-009 SS_n  output  1  slave select, active-low.
REQ-010 MOSI  output  1  serial data to the slave.
REQ-011 MISO  input  1  serial data from the slave.
REQ-012 rd_data  output  8  byte received in the last read-data frame.
REQ-013 rd_valid  output  1  one-cycle pulse: rd_data is updated.
REQ-014 done  output  1  one-cycle pulse: frame complete.

Function
REQ-015 States SHALL be IDLE, CMD, SHIFT, TAIL, WAIT_RD, RECV and GAP; ready SHALL be high only in IDLE.
REQ-016 On a clock edge in IDLE with start=1, the block SHALL latch word[9:0]={cmd,wr_data} and enter CMD; in other states start SHALL be ignored.
REQ-017 SS_n SHALL go low in the cycle after acceptance (frame cycle F0) and stay low until the frame ends.
REQ-018 CMD SHALL last 2 cycles (F0, F1) with MOSI=word[9] in both.
REQ-019 SHIFT SHALL last 10 cycles (F2..F11) with MOSI=word[9], word[8], ... word[0] (MSB first), one bit per cycle.
REQ-020 For cmd 00, 01 and 10, after SHIFT the block SHALL enter TAIL for 1 cycle (F12, MOSI=0), giving 13 SS_n-low cycles in total.
REQ-021 For cmd 11, after SHIFT the block SHALL enter WAIT_RD for MISO_DLY cycles (MOSI=0), then RECV for 8 cycles.
REQ-022 In RECV, MISO SHALL be shifted in MSB first on each rising edge (first sample is bit 7); SS_n-low length is 20+MISO_DLY.
REQ-023 After TAIL or RECV, the block SHALL drive SS_n=1 and MOSI=0, enter GAP for IDLE_GAP cycles, then enter IDLE.
REQ-024 done SHALL pulse for 1 cycle in the first GAP cycle.
REQ-025 For cmd 11 only, rd_data SHALL update and rd_valid SHALL pulse in that same cycle; otherwise rd_data SHALL hold.
REQ-026 A start held high through a frame SHALL start a new frame only on the first IDLE edge after GAP; it is not queued.
REQ-027 A frame in progress SHALL not be affected by cmd or wr_data changes after acceptance.
REQ-028 MOSI SHALL be 0 whenever SS_n=1.

Reset
REQ-029 When rst_n=0, asynchronously: state=IDLE, SS_n=1, MOSI=0, ready=1, done=0, rd_valid=0, rd_data=0x00, and all counters cleared.
REQ-030 Reset mid-frame SHALL abort the frame immediately (SS_n=1 without waiting for clk), with no done or rd_valid pulse.
REQ-031 The first start accepted after rst_n deasserts SHALL produce a normal full frame.

Verification
REQ-032 Write-address cmd=00, wr_data=0xA5 -> the bench shall check: SS_n low 13 cycles; MOSI F0..F12 = 0,0,0,0,1,0,1,0,0,1,0,1,0; done pulses once; rd_valid stays 0.
REQ-033 Read-data cmd=11, wr_data=0x00, MISO driving 0x3C MSB-first during RECV -> the bench shall check: SS_n low 24 cycles (MISO_DLY=4); rd_data=0x3C; rd_valid and done pulse together.
REQ-034 Read-address cmd=10, wr_data=0xFF -> the bench shall check: MOSI = 1,1,1,0,1,1,1,1,1,1,1,1,0; 13 SS_n-low cycles; no rd_valid.
REQ-035 start pulsed during SHIFT and start held high continuously -> the bench shall check: the mid-frame pulse is ignored; with start held high, the next SS_n falling edge comes exactly IDLE_GAP+1 cycles after SS_n rises.
REQ-036 rst_n low at F6 of a write frame -> the bench shall check: SS_n=1 and MOSI=0 before the next clk edge; no done pulse; a following cmd=01, wr_data=0x5A frame is bit-exact.
REQ-037 Two read-data frames with MISO 0x81 then 0x7E -> the bench shall check: rd_data=0x81 after frame 1, holds through frame 2, then becomes 0x7E.
